// File: rtl/ialu_pkg.sv
// Shared IALU definitions: flag bit positions, command encodings and the
// packed {C,Z,N,V} flag record used by the main-sum adder.
package ialu_pkg;

   localparam int unsigned FLAG_C = 3;
   localparam int unsigned FLAG_Z = 2;
   localparam int unsigned FLAG_N = 1;
   localparam int unsigned FLAG_V = 0;

   localparam logic CMD_SUB = 1'b0;
   localparam logic CMD_ADD = 1'b1;

   // First member is the MSB, so the packed layout matches FLAG_* positions
   typedef struct packed {
      logic c;
      logic z;
      logic n;
      logic v;
   } flags_t;

endpackage

// File: rtl/intf.sv
// Bench-side bundle of the main_adder data ports (everything but clk/rst).
interface intf #(
   parameter int unsigned WIDTH = 32
);

   logic [WIDTH-1:0] exu2ialu_main_op1_i;
   logic [WIDTH-1:0] exu2ialu_main_op2_i;
   logic             exu2ialu_cmd_i;
   logic [WIDTH:0]   main_sum_res_out;
   logic             main_sum_pos_ovflw;
   logic             main_sum_neg_ovflw;
   logic [3:0]       main_sum_flags_out;
   logic [WIDTH:0]   main_sum_res_q;
   logic [3:0]       main_sum_flags_q;

endinterface

// File: rtl/main_adder_flags.sv
// Combinational CZNV flag and signed-ordering overflow generator for the
// main-sum adder. Overflow always uses the subtract-form equations on the
// raw operands, whatever the command.
module main_adder_flags
   import ialu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             cmd,
   input  logic [WIDTH:0]   res,
   output logic             pos_ovflw,
   output logic             neg_ovflw,
   output flags_t           flags
);

   logic a_msb;
   logic b_msb;
   logic r_msb;

   // Derive overflow indications and the flag record from the raw sum
   always_comb begin
      a_msb     = op_a[WIDTH-1];
      b_msb     = op_b[WIDTH-1];
      r_msb     = res[WIDTH-1];

      pos_ovflw = ~a_msb &  b_msb &  r_msb;
      neg_ovflw =  a_msb & ~b_msb & ~r_msb;

      flags.c   = (cmd == CMD_ADD) ? res[WIDTH] : ~res[WIDTH];
      flags.z   = (res[WIDTH-1:0] == '0);
      flags.n   = r_msb;
      flags.v   = pos_ovflw | neg_ovflw;
   end

endmodule

// File: rtl/main_adder.sv
// IALU main-sum add/subtract unit: combinational result, overflow and
// CZNV flags, plus a registered copy of result and flags for later stages.
module main_adder
   import ialu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] exu2ialu_main_op1_i,
   input  logic [WIDTH-1:0] exu2ialu_main_op2_i,
   input  logic             exu2ialu_cmd_i,
   output logic [WIDTH:0]   main_sum_res_out,
   output logic             main_sum_pos_ovflw,
   output logic             main_sum_neg_ovflw,
   output logic [3:0]       main_sum_flags_out,
   output logic [WIDTH:0]   main_sum_res_q,
   output logic [3:0]       main_sum_flags_q
);

   logic [WIDTH-1:0] op2_eff;
   logic             cin;
   flags_t           flags;

   // Subtract is A + ~B + 1; the top bit keeps the raw carry-out
   always_comb begin
      op2_eff          = (exu2ialu_cmd_i == CMD_ADD) ? exu2ialu_main_op2_i
                                                     : ~exu2ialu_main_op2_i;
      cin              = ~exu2ialu_cmd_i;
      main_sum_res_out = {1'b0, exu2ialu_main_op1_i} + {1'b0, op2_eff}
                       + {{WIDTH{1'b0}}, cin};
   end

   main_adder_flags #(
      .WIDTH (WIDTH)
   ) u_flags (
      .op_a      (exu2ialu_main_op1_i),
      .op_b      (exu2ialu_main_op2_i),
      .cmd       (exu2ialu_cmd_i),
      .res       (main_sum_res_out),
      .pos_ovflw (main_sum_pos_ovflw),
      .neg_ovflw (main_sum_neg_ovflw),
      .flags     (flags)
   );

   assign main_sum_flags_out = flags;

   // Pipeline copy of result and flags; reset clears only these registers
   always_ff @(posedge clk) begin
      if (rst) begin
         main_sum_res_q   <= '0;
         main_sum_flags_q <= '0;
      end else begin
         main_sum_res_q   <= main_sum_res_out;
         main_sum_flags_q <= main_sum_flags_out;
      end
   end

endmodule

// File: tb/tb_main_adder.sv
// Self-checking bench for main_adder: directed vector table, randomized
// vectors against an arithmetic reference model, and reset sequences.
module tb_main_adder;
   import ialu_pkg::*;

   localparam int unsigned W = 32;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   intf #(.WIDTH(W)) bus ();

   main_adder #(
      .WIDTH (W)
   ) dut (
      .clk                 (clk),
      .rst                 (rst),
      .exu2ialu_main_op1_i (bus.exu2ialu_main_op1_i),
      .exu2ialu_main_op2_i (bus.exu2ialu_main_op2_i),
      .exu2ialu_cmd_i      (bus.exu2ialu_cmd_i),
      .main_sum_res_out    (bus.main_sum_res_out),
      .main_sum_pos_ovflw  (bus.main_sum_pos_ovflw),
      .main_sum_neg_ovflw  (bus.main_sum_neg_ovflw),
      .main_sum_flags_out  (bus.main_sum_flags_out),
      .main_sum_res_q      (bus.main_sum_res_q),
      .main_sum_flags_q    (bus.main_sum_flags_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        cmd;
      logic [32:0] res;
      logic        pos;
      logic        neg;
      logic [3:0]  fl;
   } vec_t;

   vec_t tbl[8];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: plain unsigned/signed arithmetic on the operands
   function automatic vec_t model(input logic [31:0] a, input logic [31:0] b, input logic cmd);
      vec_t v;
      longint unsigned la, lb, full;
      logic carry;
      logic [31:0] r;
      la = 64'(a);
      lb = 64'(b);
      if (cmd == CMD_ADD) begin
         full  = la + lb;
         r     = full[31:0];
         carry = full[32];
      end else begin
         r     = a - b;
         carry = (a >= b);           // no borrow means the raw carry is set
      end
      v.a = a; v.b = b; v.cmd = cmd;
      v.res = {carry, r};
      v.pos = ($signed(a) >= 0) && ($signed(b) < 0) && ($signed(r) < 0);
      v.neg = ($signed(a) < 0) && ($signed(b) >= 0) && ($signed(r) >= 0);
      v.fl  = '0;
      v.fl[FLAG_C] = (cmd == CMD_ADD) ? carry : (a < b);
      v.fl[FLAG_Z] = (r == 0);
      v.fl[FLAG_N] = ($signed(r) < 0);
      v.fl[FLAG_V] = v.pos | v.neg;
      return v;
   endfunction

   task automatic apply(input vec_t v);
      bus.exu2ialu_main_op1_i = v.a;
      bus.exu2ialu_main_op2_i = v.b;
      bus.exu2ialu_cmd_i      = v.cmd;
      #1;
   endtask

   task automatic check_comb(input string tag, input vec_t v);
      check({tag, ".res"},   64'(bus.main_sum_res_out),   64'(v.res));
      check({tag, ".pos"},   64'(bus.main_sum_pos_ovflw), 64'(v.pos));
      check({tag, ".neg"},   64'(bus.main_sum_neg_ovflw), 64'(v.neg));
      check({tag, ".flags"}, 64'(bus.main_sum_flags_out), 64'(v.fl));
   endtask

   task automatic check_q(input string tag, input vec_t v);
      check({tag, ".res_q"},   64'(bus.main_sum_res_q),   64'(v.res));
      check({tag, ".flags_q"}, 64'(bus.main_sum_flags_q), 64'(v.fl));
   endtask

   initial begin
      vec_t v;
      vec_t zero;
      logic [31:0] ra, rb;
      checks   = 0;
      failures = 0;

      //          a             b             cmd   res            pos   neg   flags
      tbl[0] = '{32'h00000001, 32'h00000002, 1'b1, 33'h000000003, 1'b0, 1'b0, 4'h0};
      tbl[1] = '{32'h00000005, 32'h00000003, 1'b0, 33'h100000002, 1'b0, 1'b0, 4'h0};
      tbl[2] = '{32'h00000000, 32'h00000001, 1'b0, 33'h0FFFFFFFF, 1'b0, 1'b0, 4'hA};
      tbl[3] = '{32'hFFFFFFFF, 32'h00000001, 1'b1, 33'h100000000, 1'b0, 1'b1, 4'hD};
      tbl[4] = '{32'h7FFFFFFF, 32'h80000000, 1'b1, 33'h0FFFFFFFF, 1'b1, 1'b0, 4'h3};
      tbl[5] = '{32'h80000000, 32'h00000001, 1'b0, 33'h17FFFFFFF, 1'b0, 1'b1, 4'h1};
      tbl[6] = '{32'h87654321, 32'h12345678, 1'b1, 33'h099999999, 1'b0, 1'b0, 4'h2};
      tbl[7] = '{32'h00000000, 32'h00000000, 1'b1, 33'h000000000, 1'b0, 1'b0, 4'h4};

      zero = '{32'h0, 32'h0, 1'b1, 33'h0, 1'b0, 1'b0, 4'h0};

      // Reset held for two edges clears the registered copies
      rst = 1'b1;
      apply(tbl[3]);
      @(negedge clk);
      @(posedge clk);
      @(posedge clk);
      #1;
      check_q("reset", zero);

      // Release reset, 1+2 lands in the registers on the next edge
      @(negedge clk);
      rst = 1'b0;
      apply(tbl[0]);
      check_comb("seq_add", tbl[0]);
      @(posedge clk);
      #1;
      check_q("seq_add", tbl[0]);

      // Reset while driving FFFFFFFF+1: comb path unaffected, _q cleared
      @(negedge clk);
      rst = 1'b1;
      apply(tbl[3]);
      check_comb("rst_comb", tbl[3]);
      @(posedge clk);
      #1;
      check_q("rst_q", zero);
      check_comb("rst_comb_after", tbl[3]);
      @(negedge clk);
      rst = 1'b0;

      // Directed table, each vector also checked through the register
      for (int unsigned i = 0; i < 8; i++) begin
         @(negedge clk);
         apply(tbl[i]);
         check_comb($sformatf("tbl%0d", i), tbl[i]);
         @(posedge clk);
         #1;
         check_q($sformatf("tbl%0d", i), tbl[i]);
      end

      // Randomized vectors with occasional corner operands
      for (int unsigned i = 0; i < 300; i++) begin
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 5))
            0: ra = 32'h80000000;
            1: rb = 32'h7FFFFFFF;
            2: rb = ra;
            3: ra = 32'hFFFFFFFF;
            default: ;
         endcase
         v = model(ra, rb, 1'($urandom_range(0, 1)));
         @(negedge clk);
         apply(v);
         check_comb($sformatf("rnd%0d", i), v);
         @(posedge clk);
         #1;
         check_q($sformatf("rnd%0d", i), v);
      end

      // Model cross-checks the directed expectations too
      for (int unsigned i = 0; i < 8; i++) begin
         v = model(tbl[i].a, tbl[i].b, tbl[i].cmd);
         @(negedge clk);
         apply(v);
         check_comb($sformatf("mdl%0d", i), v);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/main_adder.md
Name: main_adder

Overview:
- Integer add/subtract unit for the IALU main-sum path.
- Computes op1 + op2 or op1 − op2 combinationally and produces:
  - a (WIDTH+1)-bit result including the raw carry;
  - signed-ordering overflow indications;
  - a 4-bit CZNV flag vector.
- Also holds a registered copy of the last result and flags for downstream pipeline stages.

Parameters:
- WIDTH, 32, operand/result data width (bench vectors use 32).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- exu2ialu_main_op1_i  in  WIDTH  operand A.
- exu2ialu_main_op2_i  in  WIDTH  operand B.
- exu2ialu_cmd_i  in  1  1 = add (A+B), 0 = subtract (A−B).
- main_sum_res_out  out  WIDTH+1  [WIDTH-1:0] = sum/difference, [WIDTH] = raw carry-out; combinational.
- main_sum_pos_ovflw  out  1  positive-overflow indication; combinational.
- main_sum_neg_ovflw  out  1  negative-overflow indication; combinational.
- main_sum_flags_out  out  4  {C,Z,N,V}, bit3..bit0; combinational.
- main_sum_res_q  out  WIDTH+1  registered main_sum_res_out.
- main_sum_flags_q  out  4  registered main_sum_flags_out.

Behaviour:
- Combinational path, zero latency: outputs follow inputs within the same cycle with no clock dependence.
- Arithmetic: B' = cmd ? B : ~B; cin = ~cmd.
  - res = {1'b0,A} + {1'b0,B'} + cin, (WIDTH+1) bits.
  - Wrap-around modulo 2^WIDTH in res[WIDTH-1:0].
- Overflow outputs always use the subtract-form (signed A-vs-B ordering) equations, independent of cmd. Let a = A[MSB], b = B[MSB] (raw op2, not B'), r = res[WIDTH-1].
  - pos_ovflw = ~a & b & r.
  - neg_ovflw = a & ~b & ~r.
  - The two are mutually exclusive by construction.
- Flags:
  - C (bit3) = cmd ? res[WIDTH] : ~res[WIDTH]. Carry on add, borrow on subtract.
  - Z (bit2) = (res[WIDTH-1:0] == 0).
  - N (bit1) = res[WIDTH-1].
  - V (bit0) = pos_ovflw | neg_ovflw.
- Registered copies:
  - On each rising clk, main_sum_res_q and main_sum_flags_q load the current combinational values.
  - When rst = 1 at a rising edge, both load 0; rst takes priority over the load.
  - No enable; the registers update every cycle.
  - Reset mid-operation affects only the _q outputs; the combinational outputs are never gated by rst.
- X-propagation: no special handling; no latches.

Decomposition:
- Shared package ialu_pkg holds:
  - flag bit-index constants FLAG_C = 3, FLAG_Z = 2, FLAG_N = 1, FLAG_V = 0;
  - cmd encodings CMD_SUB = 1'b0, CMD_ADD = 1'b1;
  - a packed struct for {C,Z,N,V}.
- Sub-module: main_adder_flags (pure combinational flag/overflow generator from A, B, cmd, res).
- Interface intf: the bench-side bundle of all ports except clk/rst.

Test Plan:
- Add 1+2, cmd=1 -> res[31:0]=00000003, pos=0, neg=0, flags=0x0.
- Subtract 5−3, cmd=0 -> res=00000002, flags=0x0. Subtract 0−1, cmd=0 -> res=FFFFFFFF, pos=0, neg=0, flags=0xA (borrow, N).
- Add FFFFFFFF+00000001 -> res=00000000, res[32]=1, neg=1, flags=0xD. Add 7FFFFFFF+80000000 -> res=FFFFFFFF, pos=1, flags=0x3.
- Subtract 80000000−00000001 -> res=7FFFFFFF, neg=1, pos=0, flags=0x1. Add 87654321+12345678 -> res=99999999, flags=0x2.
- Add 0+0 -> res=0, flags=0x4.
- Registered path:
  - hold rst=1 for two edges -> res_q=0, flags_q=0;
  - release rst and apply 1+2 -> after the next rising edge res_q=00000003, flags_q=0x0;
  - assert rst while driving FFFFFFFF+1 -> the combinational outputs still show flags=0xD, while the _q outputs go to 0 after the edge.
